// File: rtl/trees_spawn_ctrl.sv
// trees_spawn_ctrl: per-level controller for the trees layer.
// On startOfLevel it latches the level's tree target and scroll speed. It then
// enables trees one at a time, lowest index first. Each spawn follows a
// pseudo-random wait of MIN_GAP..MIN_GAP+15 tenth-second ticks.
module trees_spawn_ctrl #(
  parameter int unsigned TREES_COUNT     = 16,
  parameter int unsigned BASE_TREES      = 4,
  parameter int unsigned TREES_PER_LEVEL = 2,
  parameter int unsigned BASE_SPEED      = 40,
  parameter int unsigned SPEED_STEP      = 15,
  parameter int unsigned MAX_SPEED       = 200,
  parameter int unsigned MIN_GAP         = 3,
  parameter logic [3:0]  GAP_MASK        = 4'hF,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfLevel,
  input  logic                    endLevel,
  input  logic                    oneTensSec,
  input  logic [3:0]              levelNumber,
  output logic [TREES_COUNT-1:0]  enableTreesVector,
  output logic signed [31:0]      levelSpeed,
  output logic [4:0]              activeCount,
  output logic                    spawnDone
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GAP = 2'd1,
    SPAWN    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [TREES_COUNT-1:0] VEC_ONE = TREES_COUNT'(1);

  state_t                  state, state_next;
  logic [15:0]             lfsr;
  logic [7:0]              gap_cnt, gap_cnt_next;
  logic [4:0]              target, target_next;
  logic [TREES_COUNT-1:0]  vec_next;
  logic signed [31:0]      speed_next;
  logic [4:0]              count_next;
  logic                    done_next;

  // Level-dependent values. They are computed in 32 bits so that the clamp sees the true sum.
  logic [31:0] trees_raw;
  logic [31:0] speed_raw;
  logic [4:0]  level_target;
  logic [31:0] level_speed;
  logic [7:0]  gap_reload;

  assign trees_raw    = BASE_TREES + 32'(levelNumber) * TREES_PER_LEVEL;
  assign speed_raw    = BASE_SPEED + 32'(levelNumber) * SPEED_STEP;
  assign level_target = (trees_raw > TREES_COUNT) ? 5'(TREES_COUNT) : trees_raw[4:0];
  assign level_speed  = (speed_raw > MAX_SPEED) ? MAX_SPEED : speed_raw;
  assign gap_reload   = 8'(MIN_GAP) + {4'b0000, lfsr[3:0] & GAP_MASK};

  // Free-running Galois LFSR with taps x^16+x^14+x^13+x^11+1. It is reloaded only by reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr <= LFSR_SEED;
    else         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Next-state and next-output logic. startOfLevel has priority over endLevel.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned (no latches).
    state_next   = state;
    gap_cnt_next = gap_cnt;
    target_next  = target;
    vec_next     = enableTreesVector;
    speed_next   = levelSpeed;
    count_next   = activeCount;
    done_next    = spawnDone;

    if (startOfLevel) begin
      target_next  = level_target;
      speed_next   = signed'(level_speed);
      vec_next     = '0;
      count_next   = 5'd0;
      gap_cnt_next = gap_reload;
      if (level_target == 5'd0) begin
        state_next = HOLD;
        done_next  = 1'b1;
      end else begin
        state_next = WAIT_GAP;
        done_next  = 1'b0;
      end
    end else if (endLevel) begin
      state_next = IDLE;
      vec_next   = '0;
      count_next = 5'd0;
      done_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        WAIT_GAP: begin
          if (gap_cnt == 8'd0) begin
            state_next = SPAWN;
          end else if (oneTensSec) begin
            gap_cnt_next = gap_cnt - 8'd1;
            if (gap_cnt == 8'd1) state_next = SPAWN;
          end
        end
        SPAWN: begin
          // v | (v+1) sets exactly the lowest-index zero bit.
          vec_next   = enableTreesVector | (enableTreesVector + VEC_ONE);
          count_next = activeCount + 5'd1;
          if (count_next == target) begin
            state_next = HOLD;
            done_next  = 1'b1;
          end else begin
            gap_cnt_next = gap_reload;
            state_next   = WAIT_GAP;
          end
        end
        HOLD: begin
          state_next = HOLD;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  // Datapath and output registers. The vector and its count update together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gap_cnt           <= 8'd0;
      target            <= 5'd0;
      enableTreesVector <= '0;
      levelSpeed        <= BASE_SPEED;
      activeCount       <= 5'd0;
      spawnDone         <= 1'b0;
    end else begin
      gap_cnt           <= gap_cnt_next;
      target            <= target_next;
      enableTreesVector <= vec_next;
      levelSpeed        <= speed_next;
      activeCount       <= count_next;
      spawnDone         <= done_next;
    end
  end

endmodule

// File: tb/tb_trees_spawn_ctrl.sv
// Directed bench for trees_spawn_ctrl. It covers the level latch, the speed and
// target clamps, spawn ordering and gap bounds, endLevel, a start/end collision,
// and mid-HOLD asynchronous reset with LFSR repeatability.
`timescale 1ns/1ps
module tb_trees_spawn_ctrl;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfLevel;
  logic               endLevel;
  logic               oneTensSec;
  logic [3:0]         levelNumber;
  logic [15:0]        enableTreesVector;
  logic signed [31:0] levelSpeed;
  logic [4:0]         activeCount;
  logic               spawnDone;

  int total = 0;
  int bad   = 0;
  int gap_run1;
  int gap_run6;
  int gap_unused;

  always #5 clk = ~clk;

  trees_spawn_ctrl dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfLevel      (startOfLevel),
    .endLevel          (endLevel),
    .oneTensSec        (oneTensSec),
    .levelNumber       (levelNumber),
    .enableTreesVector (enableTreesVector),
    .levelSpeed        (levelSpeed),
    .activeCount       (activeCount),
    .spawnDone         (spawnDone)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: the inputs are driven at the negedge and sampled at the posedge. The outputs are
  // observed at the following negedge, where the one-cycle pulses are dropped again.
  task automatic step(input logic tick);
    oneTensSec = tick;
    @(posedge clk);
    @(negedge clk);
    oneTensSec   = 1'b0;
    startOfLevel = 1'b0;
    endLevel     = 1'b0;
  endtask

  // Run for n cycles, with a tick every 10th cycle.
  task automatic idle_ticks(input int n);
    for (int c = 0; c < n; c++) step((c % 10) == 9);
  endtask

  // Tick every 10 cycles until stop_cnt rises have been seen. Each rise is checked for the
  // expected vector and count, the gap in ticks and the spawnDone state.
  task automatic run_level(input string tag, input int target, input int stop_cnt,
                           input int budget, output int first_gap);
    int          k;
    int          ticks;
    logic [15:0] prev;
    logic        t;
    k         = 0;
    ticks     = 0;
    first_gap = -1;
    prev      = enableTreesVector;
    for (int c = 0; c < budget && k < stop_cnt; c++) begin
      t = ((c % 10) == 9);
      step(t);
      if (t) ticks++;
      if (enableTreesVector !== prev) begin
        k++;
        check({tag, "_vec"},   32'(enableTreesVector), 32'((1 << k) - 1));
        check({tag, "_count"}, 32'(activeCount), 32'(k));
        check({tag, "_gap_in_range"}, 32'(ticks >= 3 && ticks <= 18), 32'd1);
        check({tag, "_done"},  32'(spawnDone), 32'(k == target));
        if (k == 1) first_gap = ticks;
        ticks = 0;
        prev  = enableTreesVector;
      end
    end
    if (k < stop_cnt) check({tag, "_timeout_rises"}, 32'(k), 32'(stop_cnt));
  endtask

  // After a reset release at a negedge, two idle clocks step the LFSR to 0x7138.
  // Level 0 is then latched, so the first gap is 3 + 8 = 11 ticks.
  task automatic start_after_reset();
    step(1'b0);
    step(1'b0);
    levelNumber  = 4'd0;
    startOfLevel = 1'b1;
    step(1'b0);
  endtask

  initial begin
    resetN       = 1'b0;
    startOfLevel = 1'b0;
    endLevel     = 1'b0;
    oneTensSec   = 1'b0;
    levelNumber  = 4'd0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_vec",   32'(enableTreesVector), 32'h0);
    check("rst_speed", 32'(levelSpeed), 32'd40);
    check("rst_count", 32'(activeCount), 32'd0);
    check("rst_done",  32'(spawnDone), 32'd0);

    // Run 1: level 0, target 4, speed 40.
    resetN = 1'b1;
    start_after_reset();
    check("run1_speed", 32'(levelSpeed), 32'd40);
    check("run1_vec0",  32'(enableTreesVector), 32'h0);
    run_level("run1", 4, 4, 4000, gap_run1);
    check("run1_first_gap", 32'(gap_run1), 32'd11);
    check("run1_final_vec", 32'(enableTreesVector), 32'hF);
    idle_ticks(200);
    check("run1_hold_vec",   32'(enableTreesVector), 32'hF);
    check("run1_hold_done",  32'(spawnDone), 32'd1);
    check("run1_hold_count", 32'(activeCount), 32'd4);

    // Run 2: level 7 -> target min(16,18)=16, speed min(200,145)=145.
    levelNumber  = 4'd7;
    startOfLevel = 1'b1;
    step(1'b0);
    check("run2_speed", 32'(levelSpeed), 32'd145);
    check("run2_vec0",  32'(enableTreesVector), 32'h0);
    check("run2_done0", 32'(spawnDone), 32'd0);
    run_level("run2", 16, 16, 5000, gap_unused);
    check("run2_final_vec",   32'(enableTreesVector), 32'hFFFF);
    check("run2_final_count", 32'(activeCount), 32'd16);

    // Run 3: level 15 -> speed 265 clamps to 200, target 34 clamps to 16.
    levelNumber  = 4'd15;
    startOfLevel = 1'b1;
    step(1'b0);
    check("run3_speed", 32'(levelSpeed), 32'd200);
    run_level("run3", 16, 16, 5000, gap_unused);
    check("run3_final_vec",  32'(enableTreesVector), 32'hFFFF);
    check("run3_final_done", 32'(spawnDone), 32'd1);

    // Run 4: endLevel while three trees are up and the controller is waiting for the next gap.
    levelNumber  = 4'd0;
    startOfLevel = 1'b1;
    step(1'b0);
    run_level("run4", 4, 3, 3000, gap_unused);
    check("run4_vec_before_end", 32'(enableTreesVector), 32'h7);
    endLevel = 1'b1;
    step(1'b0);
    check("run4_end_vec",   32'(enableTreesVector), 32'h0);
    check("run4_end_count", 32'(activeCount), 32'd0);
    check("run4_end_done",  32'(spawnDone), 32'd0);
    check("run4_end_speed", 32'(levelSpeed), 32'd40);
    idle_ticks(300);
    check("run4_idle_vec",   32'(enableTreesVector), 32'h0);
    check("run4_idle_count", 32'(activeCount), 32'd0);

    // Run 5: startOfLevel and endLevel together mid-spawn. The restart wins: target 8, speed 70.
    levelNumber  = 4'd0;
    startOfLevel = 1'b1;
    step(1'b0);
    run_level("run5a", 4, 2, 2000, gap_unused);
    levelNumber  = 4'd2;
    startOfLevel = 1'b1;
    endLevel     = 1'b1;
    step(1'b0);
    check("run5_vec0",  32'(enableTreesVector), 32'h0);
    check("run5_count0", 32'(activeCount), 32'd0);
    check("run5_speed", 32'(levelSpeed), 32'd70);
    check("run5_done0", 32'(spawnDone), 32'd0);
    run_level("run5", 8, 8, 4000, gap_unused);
    check("run5_final_vec",  32'(enableTreesVector), 32'hFF);
    check("run5_final_done", 32'(spawnDone), 32'd1);

    // Run 6: asynchronous reset between edges while in HOLD.
    #2 resetN = 1'b0;
    #1;
    check("run6_async_vec",   32'(enableTreesVector), 32'h0);
    check("run6_async_speed", 32'(levelSpeed), 32'd40);
    check("run6_async_count", 32'(activeCount), 32'd0);
    check("run6_async_done",  32'(spawnDone), 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    start_after_reset();
    run_level("run6", 4, 4, 4000, gap_run6);
    check("run6_first_gap", 32'(gap_run6), 32'd11);
    check("run6_gap_repeats_run1", 32'(gap_run6), 32'(gap_run1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
